// File: rtl/frog_game_ctrl.sv
// Frogger LED-grid sequencer: key synchronisation, move arbitration, hit/win
// detection, and lives/score/game-over bookkeeping.
//   state  | meaning
//   S_IDLE | waiting for the first key edge after reset
//   S_PLAY | moves forwarded, collisions and goal row watched
//   S_HOLD | frog returning to start, everything ignored
//   S_OVER | no lives left, U edge restarts
module frog_game_ctrl #(
    parameter int ROWS        = 16,
    parameter int LIVES       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 7,
    parameter int MAX_SCORE   = 99
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       key_l,
    input  logic                       key_r,
    input  logic                       key_u,
    input  logic                       key_d,
    input  logic [ROWS-1:0]            frog_present,
    input  logic                       collide,
    output logic                       L,
    output logic                       R,
    output logic                       U,
    output logic                       D,
    output logic                       hit,
    output logic                       win,
    output logic [SCORE_W-1:0]         score,
    output logic [$clog2(LIVES+1)-1:0] lives,
    output logic                       game_over,
    output logic                       playing
);

    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int HOLD_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HOLD = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t               state_q;
    logic [3:0]           sync1_q, sync2_q, prev_q;
    logic [3:0]           ev;
    logic                 l_q, r_q, u_q, d_q, hit_q, win_q;
    logic                 game_over_q, playing_q;
    logic [SCORE_W-1:0]   score_q, score_inc_d;
    logic [LIVES_W-1:0]   lives_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 unused_rows;

    assign unused_rows = ^frog_present[ROWS-2:0];

    // Bit order {u, d, l, r}; event is the first synchronised cycle of a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {key_u, key_d, key_l, key_r};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign ev = sync2_q & ~prev_q;

    always_comb begin
        score_inc_d = score_q;
        if (score_q < SCORE_W'(MAX_SCORE))
            score_inc_d = score_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            l_q         <= 1'b0;
            r_q         <= 1'b0;
            u_q         <= 1'b0;
            d_q         <= 1'b0;
            hit_q       <= 1'b0;
            win_q       <= 1'b0;
            score_q     <= '0;
            lives_q     <= LIVES_W'(LIVES);
            hold_q      <= '0;
            game_over_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            l_q   <= 1'b0;
            r_q   <= 1'b0;
            u_q   <= 1'b0;
            d_q   <= 1'b0;
            hit_q <= 1'b0;
            win_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|ev) begin
                        state_q   <= S_PLAY;
                        playing_q <= 1'b1;
                    end
                end
                S_PLAY: begin
                    // hit_q gate keeps a restart hit from being followed by another
                    if (collide && !hit_q) begin
                        hit_q     <= 1'b1;
                        if (lives_q != '0)
                            lives_q <= lives_q - 1'b1;
                        hold_q    <= HOLD_W'(HOLD_CYCLES - 1);
                        state_q   <= S_HOLD;
                        playing_q <= 1'b0;
                    end else if (frog_present[ROWS-1] && !hit_q) begin
                        hit_q     <= 1'b1;
                        win_q     <= 1'b1;
                        score_q   <= score_inc_d;
                        hold_q    <= HOLD_W'(HOLD_CYCLES - 1);
                        state_q   <= S_HOLD;
                        playing_q <= 1'b0;
                    end else begin
                        u_q <= ev[3];
                        d_q <= ev[2] & ~ev[3];
                        l_q <= ev[1] & ~ev[3] & ~ev[2];
                        r_q <= ev[0] & ~ev[3] & ~ev[2] & ~ev[1];
                    end
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        if (lives_q == '0) begin
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q   <= S_PLAY;
                            playing_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                S_OVER: begin
                    if (ev[3]) begin
                        hit_q       <= 1'b1;
                        lives_q     <= LIVES_W'(LIVES);
                        score_q     <= '0;
                        state_q     <= S_PLAY;
                        game_over_q <= 1'b0;
                        playing_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign L         = l_q;
    assign R         = r_q;
    assign U         = u_q;
    assign D         = d_q;
    assign hit       = hit_q;
    assign win       = win_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign playing   = playing_q;

endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
Central sequencer for the Frogger LED grid. It converts raw direction keys into single-cycle move pulses (L, R, U, D) for the frog-light rows. It watches frog position and car collisions, and issues the shared `hit` pulse that returns the frog to its start cell. It also owns the lives count, the score, and the game-over state.

Parameters:
- ROWS, 16, number of grid rows; frog_present has one bit per row, and bit ROWS-1 is the goal row.
- LIVES, 3, lives loaded at reset and on restart.
- HOLD_CYCLES, 4, cycles spent in HOLD after a hit or win, during which moves are suppressed (set large in synthesis).
- SCORE_W, 7, score width.
- MAX_SCORE, 99, score saturation value.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- key_l, key_r, key_u, key_d, in, 1 each, raw asynchronous direction keys, active-high.
- frog_present, in, ROWS, bit i = 1 when any LED in row i holds the frog.
- collide, in, 1, frog cell overlaps a car cell this cycle.
- L, R, U, D, out, 1 each, single-cycle move pulses to every row.
- hit, out, 1, single-cycle pulse that returns the frog to its start cell.
- win, out, 1, single-cycle pulse when the frog reaches row ROWS-1.
- score, out, SCORE_W, completed crossings.
- lives, out, $clog2(LIVES+1), remaining lives.
- game_over, out, 1, high while in OVER.
- playing, out, 1, high while in PLAY.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - L/R/U/D/hit/win = 0, score = 0, lives = LIVES, game_over = 0, playing = 0.
  - Synchronizer and edge registers cleared.
- Key path:
  - Each key passes a 2-flop synchronizer, then a rising-edge detector.
  - An edge event exists for exactly 1 cycle, on the 3rd rising clk edge after the key goes high and holds.
  - A held key produces no further events.
- Move arbitration:
  - At most one edge event is accepted per cycle, priority U > D > L > R.
  - Losing same-cycle events are dropped, not queued.
  - An accepted event drives its L/R/U/D output high for that one cycle, registered.
  - Move pulses appear only in PLAY.
- IDLE:
  - The first edge event of any key moves to PLAY.
  - That event is consumed and produces no move pulse.
- PLAY (playing = 1), evaluated each cycle in this priority order:
  1. collide = 1: assert hit for 1 cycle, decrement lives, go to HOLD. Any same-cycle move is suppressed.
  2. frog_present[ROWS-1] = 1: assert hit and win for 1 cycle, increment score (saturating at MAX_SCORE), go to HOLD.
  3. Otherwise: forward the arbitrated move.
- HOLD:
  - A counter runs HOLD_CYCLES cycles, counting from the cycle after entry.
  - Moves, collide and frog_present are ignored.
  - On expiry: if lives == 0 go to OVER, else go to PLAY.
- OVER (game_over = 1):
  - All outputs are idle except score, lives and game_over.
  - A U edge event asserts hit for 1 cycle, reloads lives = LIVES, clears score = 0, and goes to PLAY.
  - Other keys are ignored.
- Event timing:
  - hit and win are registered and asserted in the cycle after the triggering input is sampled.
  - They are never high for 2 consecutive cycles.
- Counter limits:
  - lives never underflows; decrement happens only from PLAY with lives ≥ 1.
  - score holds at MAX_SCORE on further wins; win still pulses.
- Reset asserted mid-HOLD or mid-pulse returns all outputs to reset values immediately (asynchronously).

Test Plan:
1. Reset, then raise key_r → no R pulse; state enters PLAY (playing = 1). Release, raise key_r again → R high exactly 1 cycle, 3 clks after the rise.
2. In PLAY, raise key_u and key_l in the same cycle → only U pulses, for 1 cycle; no L pulse follows.
3. In PLAY with lives = 3, pulse collide 1 cycle → hit pulses 1 cycle, lives = 2, playing = 0 for HOLD_CYCLES = 4 cycles; a key edge during HOLD yields no move. playing then returns to 1.
4. Set frog_present = 16'h8000 in PLAY → hit and win pulse together, score 0 → 1. Repeat with score = 99 → score stays 99, win still pulses.
5. Three collides separated by HOLD → lives = 0, game_over = 1 after the final HOLD. key_r ignored; a key_u edge → hit pulse, lives = 3, score = 0, playing = 1.
6. Assert reset during HOLD → playing = 0, lives = 3, score = 0, game_over = 0 in the same cycle, with no clk edge required.
